// File: rtl/data_memory_pkg.sv
// Shared definitions for the latency-programmable data memory: FSM state
// encoding, default geometry and helpers that derive depth and index width.
package data_memory_pkg;

    typedef enum logic [2:0] {
        STATE_INIT   = 3'd0,
        STATE_IDLE   = 3'd1,
        STATE_WAIT   = 3'd2,
        STATE_ACCESS = 3'd3,
        STATE_ACK    = 3'd4
    } state_e;

    localparam int DEF_MEMORY_SIZE = 16384;
    localparam int DEF_BLOCK_SIZE  = 32;
    localparam int DEF_LATENCY     = 7;

    // Number of blocks held by the memory.
    function automatic int calc_depth(input int mem_bytes, input int blk_bytes);
        return mem_bytes / blk_bytes;
    endfunction

    // Width of a block index; never narrower than one bit.
    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_DEPTH  = calc_depth(DEF_MEMORY_SIZE, DEF_BLOCK_SIZE);
    localparam int DEF_ADDR_W = calc_addr_w(DEF_DEPTH);

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous block RAM with per-byte write enables and a
// registered read port. Contents are not reset; the parent zero-fills it.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYTES  = DEF_BLOCK_SIZE
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic [BYTES-1:0]     we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [BYTES*8-1:0]   wdata_i,
    output logic [BYTES*8-1:0]   rdata_o
);

    logic [BYTES*8-1:0] mem_q [DEPTH];

    // Read-before-write access: the old word is registered, enabled bytes are updated.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_o <= mem_q[addr_i];
            for (int k = 0; k < BYTES; k++) begin
                if (we_i[k]) begin
                    mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_lat.sv
// Block-addressed backing store for the data cache. Zero-fills after reset,
// then serves one request at a time with a fixed accept-to-ack latency,
// byte-masked writes and an error flag for blocks beyond the array.
module data_memory_lat
    import data_memory_pkg::*;
#(
    parameter int pMemorySize = DEF_MEMORY_SIZE,
    parameter int pBlockSize  = DEF_BLOCK_SIZE,
    parameter int pLatency    = DEF_LATENCY
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    output logic                    ready_o,
    input  logic [31:0]             addr_i,
    input  logic                    write_ctrl_i,
    input  logic [pBlockSize-1:0]   byte_en_i,
    input  logic [pBlockSize*8-1:0] write_data_i,
    output logic [pBlockSize*8-1:0] read_data_o,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int DEPTH  = calc_depth(pMemorySize, pBlockSize);
    localparam int ADDR_W = calc_addr_w(DEPTH);
    localparam int DATA_W = pBlockSize * 8;

    localparam logic [31:0]       DEPTH_32 = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        LAT_LAST = 4'(pLatency - 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] init_ptr_q;
    logic [3:0]        lat_cnt_q;

    // Request captured at the accept edge
    logic [ADDR_W-1:0] addr_p0;
    logic              wr_p0;
    logic              in_range_p0;
    logic [pBlockSize-1:0] be_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic                  accept;
    logic                  in_range_i;
    logic                  ram_en;
    logic [pBlockSize-1:0] ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    assign ready_o    = (state_q == STATE_IDLE);
    assign accept     = enable_i & ready_o;
    assign in_range_i = (addr_i < DEPTH_32);

    // State register; an asynchronous reset abandons any request in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STATE_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and RAM port control. Reads are issued one cycle before ACCESS
    // so the registered RAM output is ready at the ACCESS edge; writes happen in ACCESS.
    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = addr_p0;
        ram_wdata = wdata_p0;
        case (state_q)
            STATE_INIT: begin
                ram_en    = 1'b1;
                ram_we    = '1;
                ram_addr  = init_ptr_q;
                ram_wdata = '0;
                if (init_ptr_q == PTR_LAST) begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_IDLE: begin
                if (enable_i) begin
                    if (pLatency == 1) begin
                        state_d  = STATE_ACCESS;
                        ram_en   = in_range_i & ~write_ctrl_i;
                        ram_addr = addr_i[ADDR_W-1:0];
                    end else begin
                        state_d = STATE_WAIT;
                    end
                end
            end
            STATE_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = STATE_ACCESS;
                    ram_en  = in_range_p0 & ~wr_p0;
                end
            end
            STATE_ACCESS: begin
                state_d = STATE_ACK;
                if (in_range_p0 & wr_p0) begin
                    ram_en = 1'b1;
                    ram_we = be_p0;
                end
            end
            STATE_ACK: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_INIT;
            end
        endcase
    end

    // Zero-fill pointer walks every block once after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_ptr_q <= '0;
        end else if (state_q == STATE_INIT) begin
            init_ptr_q <= init_ptr_q + ADDR_W'(1);
        end
    end

    // Latency counter: loaded with 1 on accept, counts through WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_cnt_q <= '0;
        end else if (accept) begin
            lat_cnt_q <= 4'd1;
        end else if (state_q == STATE_WAIT) begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
        end
    end

    // Capture the request at accept so inputs are free afterwards.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_p0     <= addr_i[ADDR_W-1:0];
            wr_p0       <= write_ctrl_i;
            in_range_p0 <= in_range_i;
            be_p0       <= byte_en_i;
            wdata_p0    <= write_data_i;
        end
    end

    // Completion outputs: one-cycle ack/err, read data updated only in ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            read_data_o <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (state_q == STATE_ACCESS) begin
                ack_o <= 1'b1;
                err_o <= ~in_range_p0;
                if (!in_range_p0) begin
                    read_data_o <= '0;
                end else if (!wr_p0) begin
                    read_data_o <= ram_rdata;
                end
            end
        end
    end

    data_memory_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYTES  (pBlockSize)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_lat.sv
// Randomized bench for data_memory_lat: one instance at latency 7 for the
// functional and reset checks, one at latency 1 for back-to-back throughput.
module tb_data_memory_lat;

    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst;

    logic         en0, rdy0, wr0, ack0, err0;
    logic [31:0]  addr0, be0;
    logic [255:0] wd0, rd0;

    logic         en1, rdy1, wr1, ack1, err1;
    logic [31:0]  addr1, be1;
    logic [255:0] wd1, rd1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: plain block arrays and last-returned data per instance
    logic [255:0] mem_m [2][DEPTH];
    logic [255:0] last_rd [2];

    typedef struct {
        int           acc;
        logic         wr;
        logic [31:0]  a;
        logic [31:0]  be;
        logic [255:0] d;
    } req_t;

    req_t pend[$];

    always #5 clk = ~clk;

    data_memory_lat #(.pMemorySize(16384), .pBlockSize(32), .pLatency(7)) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .ready_o(rdy0), .addr_i(addr0),
        .write_ctrl_i(wr0), .byte_en_i(be0), .write_data_i(wd0), .read_data_o(rd0),
        .ack_o(ack0), .err_o(err0)
    );

    data_memory_lat #(.pMemorySize(16384), .pBlockSize(32), .pLatency(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .ready_o(rdy1), .addr_i(addr1),
        .write_ctrl_i(wr1), .byte_en_i(be1), .write_data_i(wd1), .read_data_o(rd1),
        .ack_o(ack1), .err_o(err1)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'd512 + $urandom_range(0, 100000);
        return $urandom_range(0, 15);
    endfunction

    function automatic logic [31:0] rand_be();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[u][i] = '0;
            last_rd[u] = '0;
        end
    endtask

    // Apply one completed request to the model and return what the ack should show
    task automatic model_do(input int u, input logic wr, input logic [31:0] a, input logic [31:0] be,
                            input logic [255:0] d, output logic exp_err, output logic [255:0] exp_rd);
        exp_err = (a >= 32'd512);
        if (exp_err) begin
            last_rd[u] = '0;
        end else if (wr) begin
            for (int k = 0; k < 32; k++)
                if (be[k]) mem_m[u][a][k*8 +: 8] = d[k*8 +: 8];
        end else begin
            last_rd[u] = mem_m[u][a];
        end
        exp_rd = last_rd[u];
    endtask

    task automatic wait_init();
        int n;
        rst = 1'b0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("init_cycles", n, 512);
        check_val("init_ready_lat1", rdy1, 1'b1);
    endtask

    task automatic req0(input logic wr, input logic [31:0] a, input logic [31:0] be,
                        input logic [255:0] d, input string tag);
        int n;
        logic e_err;
        logic [255:0] e_rd;
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_ready"}, rdy0, 1'b1);
        en0 = 1'b1; wr0 = wr; addr0 = a; be0 = be; wd0 = d;
        @(negedge clk);
        n = 0;
        while (ack0 !== 1'b1 && n < 40) begin
            en0 = 1'($urandom_range(0, 1));
            wr0 = 1'($urandom_range(0, 1));
            addr0 = $urandom; be0 = $urandom; wd0 = rand256();
            @(negedge clk);
            n++;
        end
        en0 = 1'b0;
        check_val({tag, "_latency"}, n, 7);
        model_do(0, wr, a, be, d, e_err, e_rd);
        check_val({tag, "_err"}, err0, e_err);
        check_val({tag, "_data"}, rd0, e_rd);
        @(negedge clk);
        check_val({tag, "_ack_pulse"}, {ack0, err0}, 2'b00);
    endtask

    initial begin
        int n_acc, prev_acc, ack_seen;
        logic e_err;
        logic [255:0] e_rd;
        req_t r;

        rst = 1'b1;
        en0 = 0; wr0 = 0; addr0 = 0; be0 = 0; wd0 = 0;
        en1 = 0; wr1 = 0; addr1 = 0; be1 = 0; wd1 = 0;
        model_clear();
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {rdy0, ack0, err0, rd0}, '0);

        // Initialisation sweep and first read
        wait_init();
        req0(1'b0, 32'd5, 32'h0, '0, "t1_read5");

        // Full write, then partial overwrite
        req0(1'b1, 32'd3, 32'hFFFF_FFFF, {32{8'hA5}}, "t2_wr3");
        req0(1'b0, 32'd3, 32'h0, '0, "t2_rd3");
        req0(1'b1, 32'd3, 32'h0000_000F, {256{1'b1}}, "t3_wr3");
        req0(1'b0, 32'd3, 32'h0, '0, "t3_rd3");

        // Out-of-range addresses, then in-range data undisturbed
        req0(1'b0, 32'd512, 32'h0, '0, "t4_rd512");
        req0(1'b0, 32'hFFFF_FFFF, 32'h0, '0, "t4_rdmax");
        req0(1'b1, 32'd600, 32'hFFFF_FFFF, rand256(), "t4_wr600");
        req0(1'b0, 32'd3, 32'h0, '0, "t4_rd3");

        // Empty byte mask leaves memory unchanged
        req0(1'b1, 32'd4, 32'h0, rand256(), "be0_wr4");
        req0(1'b0, 32'd4, 32'h0, '0, "be0_rd4");

        // Random mix
        for (int i = 0; i < 30; i++)
            req0(1'($urandom_range(0, 1)), rand_addr(), rand_be(), rand256(), "rnd");

        // Back-to-back requests at latency 1 with enable held high
        n_acc = 0;
        prev_acc = -100;
        for (int i = 0; i < 40; i++) begin
            if (ack1 === 1'b1) begin
                if (pend.size() == 0) begin
                    check_val("t5_spurious_ack", ack1, 1'b0);
                end else begin
                    r = pend.pop_front();
                    check_val("t5_ack_lat", i - r.acc, 2);
                    model_do(1, r.wr, r.a, r.be, r.d, e_err, e_rd);
                    check_val("t5_err", err1, e_err);
                    check_val("t5_data", rd1, e_rd);
                end
            end
            if (i < 30) begin
                en1 = 1'b1;
                wr1 = 1'($urandom_range(0, 1));
                addr1 = ($urandom_range(0, 9) == 0) ? 32'd512 + $urandom_range(0, 50) : $urandom_range(0, 7);
                be1 = rand_be();
                wd1 = rand256();
                if (rdy1 === 1'b1) begin
                    r.acc = i; r.wr = wr1; r.a = addr1; r.be = be1; r.d = wd1;
                    pend.push_back(r);
                    if (n_acc > 0) check_val("t5_gap", i - prev_acc, 3);
                    prev_acc = i;
                    n_acc++;
                end
            end else begin
                en1 = 1'b0;
            end
            @(negedge clk);
        end
        check_val("t5_accepts", n_acc, 10);
        check_val("t5_all_acked", pend.size(), 0);

        // Reset during WAIT aborts the write
        req0(1'b1, 32'd7, 32'hFFFF_FFFF, rand256(), "t6_pre_wr7");
        check_val("t6_ready", rdy0, 1'b1);
        en0 = 1'b1; wr0 = 1'b1; addr0 = 32'd7; be0 = 32'hFFFF_FFFF; wd0 = rand256();
        @(negedge clk);
        en0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 === 1'b1) ack_seen++;
        end
        check_val("t6_reset_outputs", {rdy0, ack0, err0, rd0}, '0);
        model_clear();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1) ack_seen++;
        end
        check_val("t6_no_ack", ack_seen, 0);
        rst = 1'b1;
        @(negedge clk);
        wait_init();
        req0(1'b0, 32'd7, 32'h0, '0, "t6_rd7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
